cci_mpf_shim_wro_filter_ctrl: RTL

CCI_MPF_SHIM_WRO_FILTER_CTRL -- requirements
Module: cci_mpf_shim_wro_filter_ctrl

---
 rtl/cci_mpf_shim_wro_pkg.sv | 16 +
 rtl/cci_mpf_shim_wro_rm_fifo.sv | 60 ++++++
 rtl/cci_mpf_shim_wro_filter_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cci_mpf_shim_wro_pkg.sv
// Shared types for the write-ordering filter controller and its remove queue.
package cci_mpf_shim_wro_pkg;

    // Default filter index width; instances may override it through HASH_BITS.
    localparam int unsigned HASH_BITS_DFLT = 14;

    // Filter index type at the default width.
    typedef logic [HASH_BITS_DFLT-1:0] wro_hash_t;

    // Controller phases: clear the filter RAM, then serve inserts and removes.
    typedef enum logic {
        StInit,
        StRun
    } wro_state_t;

endpackage

// File: rtl/cci_mpf_shim_wro_rm_fifo.sv
// Pending-remove queue: first-word fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module cci_mpf_shim_wro_rm_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cci_mpf_shim_wro_filter_ctrl.sv
// Write-ordering filter controller: clears a 1-bit-per-hash filter RAM after
// reset, then sets bits on insert (reporting conflicts) and clears them from a
// queue of pending removes whenever the write port is otherwise idle.
module cci_mpf_shim_wro_filter_ctrl
    import cci_mpf_shim_wro_pkg::*;
#(
    parameter int unsigned HASH_BITS     = HASH_BITS_DFLT,
    parameter int unsigned RM_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ins_valid,
    input  logic [HASH_BITS-1:0] ins_hash,
    output logic                 ins_ready,
    output logic                 ins_rsp_valid,
    output logic                 ins_rsp_conflict,
    input  logic                 rm_valid,
    input  logic [HASH_BITS-1:0] rm_hash,
    output logic [HASH_BITS-1:0] ram_raddr,
    input  logic                 ram_rdata,
    output logic                 ram_we,
    output logic [HASH_BITS-1:0] ram_waddr,
    output logic                 ram_wdata,
    output logic                 init_done,
    output logic                 err_rm_overflow,
    output logic                 stat_conflict
);

    localparam int unsigned CNT_W = $clog2(RM_FIFO_DEPTH) + 1;
    localparam logic [HASH_BITS-1:0] LAST_IDX = '1;

    wro_state_t           state_q, state_d;
    logic [HASH_BITS-1:0] sweep_q, sweep_d;
    logic                 s1_valid_q;
    logic [HASH_BITS-1:0] s1_hash_q;
    logic                 byp_hit_q, byp_data_q;
    logic                 err_q;
    logic                 in_run, ins_acc, eff_bit;

    logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [HASH_BITS-1:0] fifo_head;
    logic [CNT_W-1:0]     fifo_count;

    assign in_run          = (state_q == StRun);
    assign init_done       = in_run;
    // Keep one slot spare for the remove that may arrive alongside the last insert.
    assign ins_ready       = in_run && (fifo_count < CNT_W'(RM_FIFO_DEPTH - 1));
    assign ins_acc         = ins_valid && ins_ready;
    assign ram_raddr       = ins_acc ? ins_hash : '0;
    // RAM returns old data on read-during-write, so forward last cycle's write.
    assign eff_bit         = byp_hit_q ? byp_data_q : ram_rdata;
    assign fifo_push       = rm_valid && in_run && !fifo_full;
    assign err_rm_overflow = err_q;

    cci_mpf_shim_wro_rm_fifo #(
        .WIDTH (HASH_BITS),
        .DEPTH (RM_FIFO_DEPTH)
    ) u_rm_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifo_push),
        .data_i  (rm_hash),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Next state and write-port arbitration: sweep, then insert write, then drain.
    always_comb begin
        state_d          = state_q;
        sweep_d          = sweep_q;
        ram_we           = 1'b0;
        ram_waddr        = '0;
        ram_wdata        = 1'b0;
        ins_rsp_valid    = 1'b0;
        ins_rsp_conflict = 1'b0;
        stat_conflict    = 1'b0;
        fifo_pop         = 1'b0;
        unique case (state_q)
            StInit: begin
                sweep_d = sweep_q + 1'b1;
                if (!reset) begin
                    ram_we    = 1'b1;
                    ram_waddr = sweep_q;
                end
                if (sweep_q == LAST_IDX) state_d = StRun;
            end
            StRun: begin
                if (s1_valid_q) begin
                    ins_rsp_valid = 1'b1;
                    if (eff_bit) begin
                        ins_rsp_conflict = 1'b1;
                        stat_conflict    = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = s1_hash_q;
                        ram_wdata = 1'b1;
                    end
                end
                if (!ram_we && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = fifo_head;
                end
            end
        endcase
    end

    // State, insert pipeline, bypass and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            sweep_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_hash_q  <= '0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            s1_valid_q <= ins_acc;
            s1_hash_q  <= ins_hash;
            byp_hit_q  <= ram_we && (ram_waddr == ins_hash);
            byp_data_q <= ram_wdata;
            err_q      <= err_q | (rm_valid && (!in_run || fifo_full));
        end
    end

endmodule
